// File: rtl/gic_slave.sv
// gic_slave: far end of the GIC link. Decodes nibble-serial requests from the GIC master,
// replays each one as a single classic Wishbone master cycle, then returns the status and,
// for reads, eight data nibbles plus a checksum.
//
// Ports
//   wb_clk_i, wb_rst_ni         clock (also samples the GIC lines), async active-low reset
//   gic_dat_i, gic_cs_i         nibble from the master, bus ownership (1 = slave drives)
//   gic_dat_o                   registered nibble to the master, Idle when not transmitting
//   irq_i                       interrupt vector returned by IRQ queries
//   wb_*                        Wishbone classic master interface
module gic_slave #(
  parameter logic [3:0]  Idle  = 4'b1111,
  parameter int unsigned WbTmo = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [3:0]  gic_dat_i,
  output logic [3:0]  gic_dat_o,
  input  logic        gic_cs_i,
  input  logic [31:0] irq_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  typedef enum logic [3:0] {
    RInit, RCmd, RSel, RAdr, RDat, RCks, WBus, TWait, TInit, TResp, TDat, TCks
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  cks_q, cks_d, tcks_q, tcks_d;
  logic        we_q, we_d, irq_q, irq_d, rty_q, rty_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic [7:0]  tmo_q, tmo_d;
  // Buffered last response, replayed verbatim on a retry request.
  logic [1:0]  resp_q, resp_d;
  logic        lwe_q, lwe_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  out_q, out_d;

  logic [3:0]  last_tag;
  logic        r_abort;

  // The final nibble of every 8-nibble field is salted into the checksum.
  assign last_tag = (cnt_q == 3'd0) ? 4'b1100 : 4'b0000;
  assign r_abort  = gic_cs_i && (state_q inside {RCmd, RSel, RAdr, RDat, RCks});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cks_d   = cks_q;
    tcks_d  = tcks_q;
    we_d    = we_q;
    irq_d   = irq_q;
    rty_d   = rty_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    tmo_d   = tmo_q;
    resp_d  = resp_q;
    lwe_d   = lwe_q;
    rdata_d = rdata_q;
    out_d   = Idle;

    if (r_abort) begin
      state_d = RInit;
    end else begin
      unique case (state_q)
        RInit: if (!gic_cs_i && gic_dat_i == 4'b1010) state_d = RCmd;
        RCmd: begin
          we_d    = gic_dat_i[3];
          irq_d   = gic_dat_i[2];
          rty_d   = gic_dat_i[1];
          state_d = RSel;
        end
        RSel: begin
          sel_d   = gic_dat_i;
          cks_d   = gic_dat_i;
          cnt_d   = 3'd7;
          state_d = RAdr;
        end
        RAdr: begin
          adr_d[{cnt_q, 2'b00} +: 4] = gic_dat_i;
          cks_d = cks_q ^ gic_dat_i ^ last_tag;
          cnt_d = cnt_q - 3'd1;  // wraps to 7, ready for the data field
          if (cnt_q == 3'd0) state_d = we_q ? RDat : RCks;
        end
        RDat: begin
          dat_d[{cnt_q, 2'b00} +: 4] = gic_dat_i;
          cks_d = cks_q ^ gic_dat_i ^ last_tag;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_d = RCks;
        end
        RCks: begin
          state_d = TWait;
          if (rty_q) begin
            // replay: leave the response buffer untouched
          end else if (gic_dat_i != cks_q) begin
            resp_d  = 2'b01;
            lwe_d   = we_q;
            rdata_d = '0;
          end else if (irq_q) begin
            resp_d  = 2'b00;
            lwe_d   = 1'b0;
            rdata_d = irq_i;
          end else begin
            cyc_d   = 1'b1;
            tmo_d   = '0;
            state_d = WBus;
          end
        end
        WBus: begin
          tmo_d = tmo_q + 8'd1;
          lwe_d = we_q;
          if (wb_ack_i || wb_err_i || wb_rty_i || tmo_q == 8'(WbTmo - 1)) begin
            cyc_d   = 1'b0;
            state_d = TWait;
            rdata_d = '0;
            if (wb_ack_i) begin
              resp_d = 2'b00;
              if (!we_q) rdata_d = wb_dat_i;
            end else if (wb_err_i) begin
              resp_d = 2'b10;
            end else if (wb_rty_i) begin
              resp_d = 2'b11;
            end else begin
              resp_d = 2'b10;  // timeout
            end
          end
        end
        TWait: if (gic_cs_i) state_d = TInit;
        TInit: state_d = TResp;
        TResp: begin
          cnt_d   = 3'd7;
          tcks_d  = '0;
          state_d = lwe_q ? RInit : TDat;
        end
        TDat: begin
          tcks_d = tcks_q ^ rdata_q[{cnt_q, 2'b00} +: 4] ^ last_tag;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_d = TCks;
        end
        TCks: state_d = RInit;
        default: state_d = RInit;
      endcase
    end

    // Output is registered, so it is chosen from the state being entered.
    unique case (state_d)
      TInit:   out_d = 4'b0101;
      TResp:   out_d = {resp_d, 2'b00};
      TDat:    out_d = rdata_d[{cnt_d, 2'b00} +: 4];
      TCks:    out_d = tcks_d;
      default: out_d = Idle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= RInit;
      cnt_q   <= '0;
      cks_q   <= '0;
      tcks_q  <= '0;
      we_q    <= 1'b0;
      irq_q   <= 1'b0;
      rty_q   <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      tmo_q   <= '0;
      resp_q  <= '0;
      lwe_q   <= 1'b0;
      rdata_q <= '0;
      out_q   <= Idle;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cks_q   <= cks_d;
      tcks_q  <= tcks_d;
      we_q    <= we_d;
      irq_q   <= irq_d;
      rty_q   <= rty_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      tmo_q   <= tmo_d;
      resp_q  <= resp_d;
      lwe_q   <= lwe_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
    end
  end

  assign gic_dat_o = out_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q & cyc_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cti_o  = 3'b000;
  assign wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_gic_slave.sv
// Directed bench for gic_slave: plays the GIC master and a configurable Wishbone slave.
module tb_gic_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  gic_dat_i, gic_dat_o;
  logic        gic_cs_i;
  logic [31:0] irq_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  int checks = 0;
  int errors = 0;

  // Wishbone slave behaviour: 0 ack, 1 err, 2 rty, 3 silent
  int          wb_mode = 0;
  int          wb_wait = 0;
  logic [31:0] wb_rdata = '0;
  int          n_cyc = 0;
  int          hi_cnt = 0;
  int          wait_cnt = 0;
  logic        in_cyc = 1'b0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  gic_slave dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .gic_dat_i (gic_dat_i),
    .gic_dat_o (gic_dat_o),
    .gic_cs_i  (gic_cs_i),
    .irq_i     (irq_i),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cti_o  (wb_cti_o),
    .wb_bte_o  (wb_bte_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] fold(input logic [31:0] v);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 8; i++) r ^= v[i*4 +: 4];
    return r ^ 4'hC;
  endfunction

  // Wishbone slave: responds on negedges, one-cycle terminating pulse.
  initial begin
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (wb_cyc_o && wb_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1; n_cyc++; hi_cnt = 0; wait_cnt = 0;
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
        end
        hi_cnt++;
        if (wb_mode != 3 && wait_cnt == wb_wait) begin
          wb_dat_i = wb_rdata;
          if (wb_mode == 0) wb_ack_i = 1;
          else if (wb_mode == 1) wb_err_i = 1;
          else wb_rty_i = 1;
        end
        wait_cnt++;
      end else begin
        in_cyc = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [3:0] cmd, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input logic bad_cks);
    logic [3:0] cks;
    cks = sel ^ fold(adr) ^ (cmd[3] ? fold(dat) : 4'h0);
    if (bad_cks) cks = cks ^ 4'h1;
    @(negedge clk); gic_cs_i = 0; gic_dat_i = 4'b1010;
    @(negedge clk); gic_dat_i = cmd;
    @(negedge clk); gic_dat_i = sel;
    for (int i = 7; i >= 0; i--) begin @(negedge clk); gic_dat_i = adr[i*4 +: 4]; end
    if (cmd[3]) for (int i = 7; i >= 0; i--) begin @(negedge clk); gic_dat_i = dat[i*4 +: 4]; end
    @(negedge clk); gic_dat_i = cks;
    @(negedge clk); gic_cs_i = 1; gic_dat_i = 4'hF;
  endtask

  task automatic recv_frame(input string tag, input logic is_read, input logic [3:0] resp,
                            input logic [31:0] data, input logic [3:0] cks);
    logic        found = 1'b0;
    logic [31:0] word = '0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (gic_dat_o == 4'b0101) found = 1'b1;
    end
    check_eq({tag, "_start"}, 32'(found), 32'd1);
    if (!found) return;
    @(negedge clk); check_eq({tag, "_resp"}, 32'(gic_dat_o), 32'(resp));
    if (is_read) begin
      for (int i = 0; i < 8; i++) begin @(negedge clk); word = {word[27:0], gic_dat_o}; end
      check_eq({tag, "_data"}, word, data);
      @(negedge clk); check_eq({tag, "_cks"}, 32'(gic_dat_o), 32'(cks));
    end
    @(negedge clk); check_eq({tag, "_idle"}, 32'(gic_dat_o), 32'hF);
  endtask

  initial begin
    int base;
    rst_n = 0; gic_cs_i = 1; gic_dat_i = 4'hF; irq_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_dat_o", 32'(gic_dat_o), 32'hF);
    check_eq("rst_cyc", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    check_eq("rst_adr", wb_adr_o, 32'd0);
    check_eq("rst_sel", 32'(wb_sel_o), 32'd0);
    rst_n = 1;

    // 1: read with 3 wait states
    wb_mode = 0; wb_wait = 3; wb_rdata = 32'hDEADBEEF;
    send_frame(4'b0000, 4'hF, 32'h40, 32'h0, 1'b0);
    recv_frame("rd1", 1'b1, 4'b0000, 32'hDEADBEEF, 4'hC);
    check_eq("rd1_ncyc", n_cyc, 1);
    check_eq("rd1_adr", cap_adr, 32'h40);
    check_eq("rd1_we_sel", 32'({cap_we, cap_sel}), 32'h0F);
    check_eq("rd1_hi", hi_cnt, 4);
    check_eq("rd1_cti_bte", 32'({wb_cti_o, wb_bte_o}), 32'd0);

    // 2: write
    wb_wait = 1;
    send_frame(4'b1000, 4'h3, 32'h10, 32'h12345678, 1'b0);
    recv_frame("wr", 1'b0, 4'b0000, 32'h0, 4'h0);
    check_eq("wr_ncyc", n_cyc, 2);
    check_eq("wr_adr", cap_adr, 32'h10);
    check_eq("wr_dat", cap_dat, 32'h12345678);
    check_eq("wr_we_sel", 32'({cap_we, cap_sel}), 32'h13);

    // 3: corrupted checksum
    send_frame(4'b0000, 4'hF, 32'h40, 32'h0, 1'b1);
    recv_frame("bad", 1'b1, 4'b0100, 32'h0, 4'hC);
    check_eq("bad_ncyc", n_cyc, 2);

    // 4: timeout, err, rty
    wb_mode = 3;
    send_frame(4'b0000, 4'hF, 32'h80, 32'h0, 1'b0);
    recv_frame("tmo", 1'b1, 4'b1000, 32'h0, 4'hC);
    check_eq("tmo_hi", hi_cnt, 255);
    wb_mode = 1; wb_wait = 2;
    send_frame(4'b0000, 4'hF, 32'h84, 32'h0, 1'b0);
    recv_frame("err", 1'b1, 4'b1000, 32'h0, 4'hC);
    wb_mode = 2; wb_wait = 0;
    send_frame(4'b0000, 4'hF, 32'h88, 32'h0, 1'b0);
    recv_frame("rty", 1'b1, 4'b1100, 32'h0, 4'hC);
    check_eq("rty_ncyc", n_cyc, 5);

    // 5: read, replay, irq
    wb_mode = 0; wb_wait = 0; wb_rdata = 32'h0BADF00D;
    send_frame(4'b0000, 4'hF, 32'h20, 32'h0, 1'b0);
    recv_frame("rd2", 1'b1, 4'b0000, 32'h0BADF00D, 4'h2);
    base = n_cyc;
    send_frame(4'b0010, 4'hF, 32'h20, 32'h0, 1'b0);
    recv_frame("replay", 1'b1, 4'b0000, 32'h0BADF00D, 4'h2);
    check_eq("replay_ncyc", n_cyc, base);
    irq_i = 32'hA5A5A5A5;
    send_frame(4'b0100, 4'hF, 32'h0, 32'h0, 1'b0);
    recv_frame("irq", 1'b1, 4'b0000, 32'hA5A5A5A5, 4'hC);
    check_eq("irq_ncyc", n_cyc, base);

    // 6: reset during the bus cycle
    wb_mode = 3;
    send_frame(4'b0000, 4'hF, 32'h90, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("mid_cyc", 32'(wb_cyc_o), 32'd1);
    #2 rst_n = 0;
    #1;
    check_eq("arst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
    check_eq("arst_dat_o", 32'(gic_dat_o), 32'hF);
    @(negedge clk); rst_n = 1;
    wb_mode = 0; wb_wait = 1; wb_rdata = 32'hCAFEF00D;
    send_frame(4'b0000, 4'hF, 32'h44, 32'h0, 1'b0);
    recv_frame("post_rst", 1'b1, 4'b0000, 32'hCAFEF00D, 4'h9);
    check_eq("post_rst_adr", cap_adr, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
